dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arb_timeout.sv | 31 +++
 rtl/dmem_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester encoding, default timeout.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_PIPE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_e;

  localparam int DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/dmem_arb_timeout.sv
// Access watchdog: counts ACCESS cycles without mem_ack; expired flags the last allowed cycle.
// Combinational expired output, no backpressure.
module dmem_arb_timeout
  import dmem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] r_cnt;

  assign expired = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && !expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter (pipeline, debug); DMEM_ARB_RR_EN selects round-robin over fixed pipeline priority.
// Owner ack at N+2+k for mem_ack k cycles after mem_req; requesters stall until ack, abort to err after TIMEOUT_CYCLES.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int AW             = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [31:0]   p_wdata,
  output logic [31:0]   p_rdata,
  output logic          p_ack,
  output logic          p_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ack,
  output logic          d_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_ack,
  output logic          stall_o,
  output logic          busy_o
);

  state_e        r_state;
  owner_e        r_owner;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [31:0]   r_p_rdata;
  logic [31:0]   r_d_rdata;
  logic          r_p_ack;
  logic          r_p_err;
  logic          r_d_ack;
  logic          r_d_err;
  logic          r_busy;

  logic          w_any_req;
  logic          w_expired;
  owner_e        w_winner;

  assign w_any_req = p_req | d_req;

`ifdef DMEM_ARB_RR_EN
  owner_e r_last_owner;

  always_comb begin
    w_winner = OWN_PIPE;
    if (p_req && d_req) begin
      w_winner = (r_last_owner == OWN_PIPE) ? OWN_DBG : OWN_PIPE;
    end else if (d_req) begin
      w_winner = OWN_DBG;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_owner <= OWN_DBG;
    end else if (r_state == ST_IDLE && w_any_req) begin
      r_last_owner <= w_winner;
    end
  end
`else
  always_comb begin
    w_winner = OWN_PIPE;
    if (!p_req && d_req) begin
      w_winner = OWN_DBG;
    end
  end
`endif

  dmem_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (r_state == ST_IDLE && w_any_req),
    .enable (r_state == ST_ACCESS && !mem_ack),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_PIPE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_p_rdata   <= '0;
      r_d_rdata   <= '0;
      r_p_ack     <= 1'b0;
      r_p_err     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_d_err     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // ack/err are single-cycle pulses raised only on entry to DONE
      r_p_ack <= 1'b0;
      r_p_err <= 1'b0;
      r_d_ack <= 1'b0;
      r_d_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner     <= w_winner;
            r_mem_req   <= 1'b1;
            r_mem_we    <= (w_winner == OWN_DBG) ? d_we    : p_we;
            r_mem_addr  <= (w_winner == OWN_DBG) ? d_addr  : p_addr;
            r_mem_wdata <= (w_winner == OWN_DBG) ? d_wdata : p_wdata;
            r_busy      <= 1'b1;
            r_state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_owner == OWN_DBG) begin
              r_d_ack <= 1'b1;
              if (!r_mem_we) r_d_rdata <= mem_rdata;
            end else begin
              r_p_ack <= 1'b1;
              if (!r_mem_we) r_p_rdata <= mem_rdata;
            end
            r_state <= ST_DONE;
          end else if (w_expired) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_owner == OWN_DBG) begin
              r_d_ack   <= 1'b1;
              r_d_err   <= 1'b1;
              r_d_rdata <= '0;
            end else begin
              r_p_ack   <= 1'b1;
              r_p_err   <= 1'b1;
              r_p_rdata <= '0;
            end
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign p_rdata   = r_p_rdata;
  assign d_rdata   = r_d_rdata;
  assign p_ack     = r_p_ack;
  assign p_err     = r_p_err;
  assign d_ack     = r_d_ack;
  assign d_err     = r_d_err;
  assign busy_o    = r_busy;
  assign stall_o   = p_req & ~r_p_ack;

endmodule
